// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU interface constants and the request bundle
// that is queued between the core and the APU.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
  } apu_req_t;

endpackage

// File: rtl/cv32e40n_apu_req_fifo.sv
// In-order FIFO of APU requests; the head entry is always
// visible on rdata.
module cv32e40n_apu_req_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  apu_req_t      wdata,
  output apu_req_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  apu_req_t      mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Storage needs no reset; it is only read when count != 0.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40n_apu_req_buffer.sv
// Buffers core APU requests, throttles issue on outstanding
// operations and registers APU responses back to the core.
module cv32e40n_apu_req_buffer
  import cv32e40p_apu_core_pkg::*;
#(
  parameter  int DEPTH           = 4,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int PW = $clog2(DEPTH + MAX_OUTSTANDING + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           core_req_i,
  output logic                           core_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][31:0] core_operands_i,
  input  logic [APU_WOP_CPU-1:0]         core_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]    core_flags_i,
  output logic                           core_rvalid_o,
  output logic [31:0]                    core_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]    core_flags_o,
  output logic                           apu_req_o,
  input  logic                           apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0] apu_operands_o,
  output logic [APU_WOP_CPU-1:0]         apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]    apu_flags_o,
  input  logic                           apu_rvalid_i,
  input  logic [31:0]                    apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]    apu_flags_i,
  output logic [PW-1:0]                  pending_o,
  output logic                           err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  apu_req_t      wdata;
  apu_req_t      head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic          push;
  logic          pop;

  assign wdata = '{operands: core_operands_i,
                   op:       core_op_i,
                   flags:    core_flags_i};

  assign core_gnt_o = ~full;
  assign push       = core_req_i & core_gnt_o;
  assign apu_req_o  = ~empty &
                      (outstanding < OW'(MAX_OUTSTANDING));
  assign pop        = apu_req_o & apu_gnt_i;

  assign apu_operands_o = head.operands;
  assign apu_op_o       = head.op;
  assign apu_flags_o    = head.flags;

  assign pending_o = PW'(count) + PW'(outstanding);

  cv32e40n_apu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A response with nothing in flight is flagged, never underflowed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
      err_o       <= 1'b0;
    end else begin
      unique case ({pop, apu_rvalid_i})
        2'b10: outstanding <= outstanding + OW'(1);
        2'b01: begin
          if (outstanding != '0)
            outstanding <= outstanding - OW'(1);
          else
            err_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_rvalid_o <= 1'b0;
      core_result_o <= '0;
      core_flags_o  <= '0;
    end else begin
      core_rvalid_o <= apu_rvalid_i;
      if (apu_rvalid_i) begin
        core_result_o <= apu_result_i;
        core_flags_o  <= apu_flags_i;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40n_apu_req_buffer.sv
// Directed bench for the APU request buffer with
// hand-computed cycle-by-cycle expectations.
module tb_cv32e40n_apu_req_buffer;
  import cv32e40p_apu_core_pkg::*;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic                           core_req_i;
  logic                           core_gnt_o;
  logic [APU_NARGS_CPU-1:0][31:0] core_operands_i;
  logic [APU_WOP_CPU-1:0]         core_op_i;
  logic [APU_NDSFLAGS_CPU-1:0]    core_flags_i;
  logic                           core_rvalid_o;
  logic [31:0]                    core_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]    core_flags_o;
  logic                           apu_req_o;
  logic                           apu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0] apu_operands_o;
  logic [APU_WOP_CPU-1:0]         apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]    apu_flags_o;
  logic                           apu_rvalid_i;
  logic [31:0]                    apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]    apu_flags_i;
  logic [2:0]                     pending_o;
  logic                           err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  cv32e40n_apu_req_buffer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_operands_i (core_operands_i),
    .core_op_i       (core_op_i),
    .core_flags_i    (core_flags_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_result_o   (core_result_o),
    .core_flags_o    (core_flags_o),
    .apu_req_o       (apu_req_o),
    .apu_gnt_i       (apu_gnt_i),
    .apu_operands_o  (apu_operands_o),
    .apu_op_o        (apu_op_o),
    .apu_flags_o     (apu_flags_o),
    .apu_rvalid_i    (apu_rvalid_i),
    .apu_result_i    (apu_result_i),
    .apu_flags_i     (apu_flags_i),
    .pending_o       (pending_o),
    .err_o           (err_o)
  );

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_i      = 1'b0;
    core_operands_i = '0;
    core_op_i       = '0;
    core_flags_i    = '0;
    apu_gnt_i       = 1'b0;
    apu_rvalid_i    = 1'b0;
    apu_result_i    = '0;
    apu_flags_i     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (core_gnt_o !== 1'b1 || apu_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs gnt=%b req=%b want 1/0",
               core_gnt_o, apu_req_o);
    end
    checks++;
    if (pending_o !== 3'd0 || err_o !== 1'b0 ||
        core_rvalid_o !== 1'b0 || core_result_o !== 32'd0 ||
        core_flags_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_state pend=%0d err=%b rv=%b res=%h fl=%h",
               pending_o, err_o, core_rvalid_o, core_result_o,
               core_flags_o);
    end
    nxt();
    rst_i = 1'b0;
    nxt();
  endtask

  task automatic test_single_op();
    core_req_i      = 1'b1;
    core_operands_i = {32'd3, 32'd2, 32'd1};
    core_op_i       = 6'h05;
    core_flags_i    = 15'h1234;
    apu_gnt_i       = 1'b1;
    @(negedge clk_i);
    checks++;
    if (core_gnt_o !== 1'b1 || apu_req_o !== 1'b0) begin
      failures++;
      $display("FAIL single_c0 gnt=%b req=%b want 1/0",
               core_gnt_o, apu_req_o);
    end
    nxt();
    core_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (apu_req_o !== 1'b1 || apu_op_o !== 6'h05 ||
        apu_operands_o !== {32'd3, 32'd2, 32'd1} ||
        apu_flags_o !== 15'h1234) begin
      failures++;
      $display("FAIL single_c1 req=%b op=%h ops=%h fl=%h",
               apu_req_o, apu_op_o, apu_operands_o, apu_flags_o);
    end
    nxt();
    apu_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (apu_req_o !== 1'b0 || pending_o !== 3'd1) begin
      failures++;
      $display("FAIL single_c2 req=%b pend=%0d want 0/1",
               apu_req_o, pending_o);
    end
    nxt();
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'hDEADBEEF;
    apu_flags_i  = 5'h0A;
    nxt();
    apu_rvalid_i = 1'b0;
    apu_result_i = 32'h0;
    apu_flags_i  = 5'h0;
    @(negedge clk_i);
    checks++;
    if (core_rvalid_o !== 1'b1 || core_result_o !== 32'hDEADBEEF ||
        core_flags_o !== 5'h0A || pending_o !== 3'd0) begin
      failures++;
      $display("FAIL single_c4 rv=%b res=%h fl=%h pend=%0d",
               core_rvalid_o, core_result_o, core_flags_o, pending_o);
    end
    nxt();
    @(negedge clk_i);
    checks++;
    if (core_rvalid_o !== 1'b0 || core_result_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_hold rv=%b res=%h want 0/deadbeef",
               core_rvalid_o, core_result_o);
    end
    nxt();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      core_req_i      = 1'b1;
      core_op_i       = 6'(i + 1);
      core_operands_i = {32'(i), 32'(i), 32'(i)};
      @(negedge clk_i);
      checks++;
      if (core_gnt_o !== 1'b1) begin
        failures++;
        $display("FAIL fill_gnt%0d got=%b want 1", i, core_gnt_o);
      end
      nxt();
    end
    core_op_i = 6'd5;
    @(negedge clk_i);
    checks++;
    if (core_gnt_o !== 1'b0 || pending_o !== 3'd4 ||
        apu_op_o !== 6'd1 || apu_req_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_full gnt=%b pend=%0d op=%0d req=%b",
               core_gnt_o, pending_o, apu_op_o, apu_req_o);
    end
    nxt();
    apu_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (core_gnt_o !== 1'b0 || apu_op_o !== 6'd1) begin
      failures++;
      $display("FAIL fill_hold gnt=%b op=%0d want 0/1",
               core_gnt_o, apu_op_o);
    end
    nxt();
    apu_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (core_gnt_o !== 1'b1 || apu_op_o !== 6'd2) begin
      failures++;
      $display("FAIL fill_free gnt=%b op=%0d want 1/2",
               core_gnt_o, apu_op_o);
    end
    nxt();
    core_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pending_o !== 3'd5 || core_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_refull pend=%0d gnt=%b want 5/0",
               pending_o, core_gnt_o);
    end
    nxt();
    for (int k = 0; k < 4; k++) begin
      apu_gnt_i    = 1'b1;
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'(k + 1);
      @(negedge clk_i);
      checks++;
      if (apu_req_o !== 1'b1 || apu_op_o !== 6'(k + 2)) begin
        failures++;
        $display("FAIL fill_drain%0d req=%b op=%0d want 1/%0d",
                 k, apu_req_o, apu_op_o, k + 2);
      end
      if (k > 0) begin
        checks++;
        if (core_result_o !== 32'(k)) begin
          failures++;
          $display("FAIL fill_resp%0d got=%0d want %0d",
                   k, core_result_o, k);
        end
      end
      nxt();
    end
    apu_gnt_i    = 1'b0;
    apu_result_i = 32'd5;
    @(negedge clk_i);
    checks++;
    if (apu_req_o !== 1'b0 || core_result_o !== 32'd4) begin
      failures++;
      $display("FAIL fill_last req=%b res=%0d want 0/4",
               apu_req_o, core_result_o);
    end
    nxt();
    apu_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (core_rvalid_o !== 1'b1 || core_result_o !== 32'd5 ||
        pending_o !== 3'd0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_end rv=%b res=%0d pend=%0d err=%b",
               core_rvalid_o, core_result_o, pending_o, err_o);
    end
    nxt();
  endtask

  task automatic test_throttle();
    for (int i = 0; i < 3; i++) begin
      core_req_i = 1'b1;
      core_op_i  = 6'(8'h11 + i);
      nxt();
    end
    core_req_i = 1'b0;
    apu_gnt_i  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if (apu_req_o !== 1'b1 || apu_op_o !== 6'(8'h11 + i)) begin
        failures++;
        $display("FAIL thr_pop%0d req=%b op=%h", i, apu_req_o, apu_op_o);
      end
      nxt();
    end
    @(negedge clk_i);
    checks++;
    if (apu_req_o !== 1'b0 || pending_o !== 3'd3) begin
      failures++;
      $display("FAIL thr_block req=%b pend=%0d want 0/3",
               apu_req_o, pending_o);
    end
    nxt();
    apu_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (apu_req_o !== 1'b0) begin
      failures++;
      $display("FAIL thr_rv_cycle req=%b want 0", apu_req_o);
    end
    nxt();
    apu_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (apu_req_o !== 1'b1 || apu_op_o !== 6'h13) begin
      failures++;
      $display("FAIL thr_resume req=%b op=%h want 1/13",
               apu_req_o, apu_op_o);
    end
    nxt();
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (pending_o !== 3'd2 || apu_req_o !== 1'b0) begin
      failures++;
      $display("FAIL thr_pend pend=%0d req=%b want 2/0",
               pending_o, apu_req_o);
    end
    nxt();
    nxt();
    apu_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pending_o !== 3'd0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL thr_end pend=%0d err=%b want 0/0",
               pending_o, err_o);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      core_req_i      = (c < 8);
      core_op_i       = 6'(32 + c);
      core_operands_i = {32'(c + 2), 32'(c + 1), 32'(c)};
      apu_gnt_i       = (c >= 2 && c <= 9);
      apu_rvalid_i    = (c >= 3 && c <= 10);
      apu_result_i    = 32'(c - 3);
      @(negedge clk_i);
      if (c >= 2 && c <= 9) begin
        checks++;
        if (apu_req_o !== 1'b1 || apu_op_o !== 6'(32 + c - 2) ||
            apu_operands_o[0] !== 32'(c - 2)) begin
          failures++;
          $display("FAIL b2b_order%0d req=%b op=%h opnd=%0d",
                   c, apu_req_o, apu_op_o, apu_operands_o[0]);
        end
      end
      if (c >= 3 && c <= 7) begin
        checks++;
        if (pending_o !== 3'd3 || core_gnt_o !== 1'b1) begin
          failures++;
          $display("FAIL b2b_steady%0d pend=%0d gnt=%b want 3/1",
                   c, pending_o, core_gnt_o);
        end
      end
      if (c >= 4) begin
        checks++;
        if (core_rvalid_o !== 1'b1 || core_result_o !== 32'(c - 4)) begin
          failures++;
          $display("FAIL b2b_resp%0d rv=%b res=%0d want 1/%0d",
                   c, core_rvalid_o, core_result_o, c - 4);
        end
      end
      nxt();
    end
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (core_result_o !== 32'd7 || pending_o !== 3'd0) begin
      failures++;
      $display("FAIL b2b_end res=%0d pend=%0d want 7/0",
               core_result_o, pending_o);
    end
    nxt();
  endtask

  task automatic test_spurious();
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h55;
    apu_flags_i  = 5'h3;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL spur_pre err=%b want 0", err_o);
    end
    nxt();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1 || core_rvalid_o !== 1'b1 ||
        core_result_o !== 32'h55 || pending_o !== 3'd0) begin
      failures++;
      $display("FAIL spur_hit err=%b rv=%b res=%h pend=%0d",
               err_o, core_rvalid_o, core_result_o, pending_o);
    end
    nxt();
    nxt();
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1 || core_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL spur_sticky err=%b rv=%b want 1/0",
               err_o, core_rvalid_o);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      core_req_i = 1'b1;
      core_op_i  = 6'(i);
      nxt();
    end
    core_req_i = 1'b0;
    apu_gnt_i  = 1'b1;
    nxt();
    apu_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pending_o !== 3'd4 || apu_req_o !== 1'b1) begin
      failures++;
      $display("FAIL rstm_pre pend=%0d req=%b want 4/1",
               pending_o, apu_req_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (pending_o !== 3'd0 || apu_req_o !== 1'b0 ||
        err_o !== 1'b0 || core_gnt_o !== 1'b1 ||
        core_rvalid_o !== 1'b0 || core_result_o !== 32'd0) begin
      failures++;
      $display("FAIL rstm_async pend=%0d req=%b err=%b gnt=%b res=%h",
               pending_o, apu_req_o, err_o, core_gnt_o, core_result_o);
    end
    nxt();
    rst_i        = 1'b0;
    apu_rvalid_i = 1'b1;
    nxt();
    apu_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1 || pending_o !== 3'd0) begin
      failures++;
      $display("FAIL rstm_late err=%b pend=%0d want 1/0",
               err_o, pending_o);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fill();
    test_throttle();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
